// File: rtl/seq_alu_pipe.sv
// seq_alu_pipe: two-stage pipelined ALU with valid/ready handshakes, flags, tag pass-through and accumulator.
// Optional build macro SEQ_ALU_SAT_EN makes ADD, SUB and ACC saturate (signed) instead of wrapping.
module seq_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       opcode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic [3:0]       flags_o
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int M = WIDTH - 1;

    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, acc_q;
    logic [3:0]       op_q, flg_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [WIDTH-1:0] res_d, acc_d;
    logic [3:0]       flg_d;
    logic             s1_adv, s2_adv, c, v;
    logic [SH_W-1:0]  sh;
    logic [WIDTH:0]   add_w, sub_w, acc_w, shl_w, shr_w, asr_w;
    logic [2*WIDTH-1:0] mul_w;
    logic [WIDTH-1:0] rol_w, ror_w, add_r, sub_r, acc_r;
    logic             add_v, sub_v, acc_v;

    assign s2_adv = en_i & (~s2_valid_q | out_ready_i);
    assign s1_adv = s2_adv | (en_i & ~s1_valid_q);
    assign in_ready_o = rst_n & s1_adv;
    assign out_valid_o = s2_valid_q;
    assign result_o = res_q;
    assign out_tag_o = tag2_q;
    assign flags_o = flg_q;

    assign sh = b_q[SH_W-1:0];
    assign add_w = {1'b0, a_q} + {1'b0, b_q};
    assign sub_w = {1'b0, a_q} - {1'b0, b_q};
    assign acc_w = {1'b0, acc_q} + {1'b0, a_q};
    assign add_v = (a_q[M] == b_q[M]) & (add_w[M] != a_q[M]);
    assign sub_v = (a_q[M] != b_q[M]) & (sub_w[M] != a_q[M]);
    assign acc_v = (acc_q[M] == a_q[M]) & (acc_w[M] != acc_q[M]);
    // The extra bit below/above the operand catches the last bit shifted out as carry.
    assign shl_w = {1'b0, a_q} << sh;
    assign shr_w = {a_q, 1'b0} >> sh;
    assign asr_w = $signed({a_q, 1'b0}) >>> sh;
    assign rol_w = (a_q << sh) | (a_q >> (WIDTH - sh));
    assign ror_w = (a_q >> sh) | (a_q << (WIDTH - sh));
    assign mul_w = a_q * b_q;

`ifdef SEQ_ALU_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = ~SMAX;
    assign add_r = add_v ? (a_q[M] ? SMIN : SMAX) : add_w[M:0];
    assign sub_r = sub_v ? (a_q[M] ? SMIN : SMAX) : sub_w[M:0];
    assign acc_r = acc_v ? (acc_q[M] ? SMIN : SMAX) : acc_w[M:0];
`else
    assign add_r = add_w[M:0];
    assign sub_r = sub_w[M:0];
    assign acc_r = acc_w[M:0];
`endif

    // ALU on the S1 registers: result, flags and the accumulator value this op would leave behind
    always_comb begin
        res_d = '0;
        c = 1'b0;
        v = 1'b0;
        acc_d = acc_q;
        case (op_q)
            4'h0: begin res_d = add_r; c = add_w[WIDTH]; v = add_v; end
            4'h1: begin res_d = sub_r; c = ~sub_w[WIDTH]; v = sub_v; end
            4'h2: res_d = a_q & b_q;
            4'h3: res_d = a_q | b_q;
            4'h4: res_d = a_q ^ b_q;
            4'h5: res_d = ~a_q;
            4'h6: {c, res_d} = shl_w;
            4'h7: {res_d, c} = shr_w;
            4'h8: {res_d, c} = asr_w;
            4'h9: res_d = rol_w;
            4'hA: res_d = ror_w;
            4'hB: begin res_d = a_q; c = ~sub_w[WIDTH]; v = sub_v; end
            4'hC: begin res_d = mul_w[M:0]; c = |mul_w[2*WIDTH-1:WIDTH]; end
            4'hD: begin res_d = acc_r; c = acc_w[WIDTH]; v = acc_v; acc_d = acc_r; end
            4'hE: acc_d = '0;
            default: res_d = b_q;
        endcase
        flg_d = (op_q == 4'hB) ? {sub_w[M], a_q == b_q, c, v} : {res_d[M], res_d == '0, c, v};
    end

    // Pipeline registers; acc moves with its op into S2 so consecutive ACC ops chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            tag1_q <= '0;
            res_q <= '0;
            flg_q <= '0;
            tag2_q <= '0;
            acc_q <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid_i;
                a_q <= a_i;
                b_q <= b_i;
                op_q <= opcode_i;
                tag1_q <= in_tag_i;
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                    flg_q <= flg_d;
                    tag2_q <= tag1_q;
                    acc_q <= acc_d;
                end
            end
        end
    end
endmodule
